// File: rtl/ram_access_arbiter_if.sv
// Bundle of the requester-side and RAM-side signals of the RAM access arbiter.
// The master modport is the environment (requesters plus RAM); slave is the arbiter.
interface ram_access_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              fetchReq;
  logic [ADDR_W-1:0] fetchAddress;
  logic              fetchDone;
  logic              fetchErr;
  logic              dataReq;
  logic              dataRW;
  logic [1:0]        dataSize;
  logic [ADDR_W-1:0] dataAddress;
  logic [DATA_W-1:0] dataWrData;
  logic              dataDone;
  logic              dataErr;
  logic [DATA_W-1:0] rdData;
  logic              busy;
  logic              ramMFA;
  logic              ramRW;
  logic [1:0]        ramDataSize;
  logic [ADDR_W-1:0] ramAddress;
  logic [DATA_W-1:0] ramDataOut;
  logic [DATA_W-1:0] ramDataIn;
  logic              ramMFC;

  modport master (
    output fetchReq, fetchAddress, dataReq, dataRW, dataSize, dataAddress, dataWrData,
           ramDataIn, ramMFC,
    input  fetchDone, fetchErr, dataDone, dataErr, rdData, busy,
           ramMFA, ramRW, ramDataSize, ramAddress, ramDataOut
  );

  modport slave (
    input  fetchReq, fetchAddress, dataReq, dataRW, dataSize, dataAddress, dataWrData,
           ramDataIn, ramMFC,
    output fetchDone, fetchErr, dataDone, dataErr, rdData, busy,
           ramMFA, ramRW, ramDataSize, ramAddress, ramDataOut
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// Shares one MFA/MFC RAM port between instruction fetch and data load/store,
// with round-robin tie-breaking, alignment checking and per-phase handshake timeouts.
module ram_access_arbiter #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic                  Clk,
  input  logic                  reset,
  ram_access_arbiter_if.slave   bus
);

  // IDLE arbitrate | ISSUE MFA high, wait MFC | RELEASE wait MFC low | DONE pulse Done/Err
  typedef enum logic [1:0] {IDLE, ISSUE, RELEASE, DONE} state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  state_t            state;
  logic [TO_W-1:0]   toCount;
  logic              errFlag;
  logic              ownerData;
  logic              lastGrant;   // 1 = data was granted last

  logic              grantAny;
  logic              grantData;
  logic              selRW;
  logic [1:0]        selSize;
  logic [ADDR_W-1:0] selAddr;
  logic              badReq;
  logic              finishErr;

  always_comb begin
    grantAny  = bus.fetchReq | bus.dataReq;
    grantData = (bus.fetchReq && bus.dataReq) ? ~lastGrant : bus.dataReq;
    selAddr   = grantData ? bus.dataAddress : bus.fetchAddress;
    selRW     = grantData ? bus.dataRW : 1'b1;
    selSize   = grantData ? bus.dataSize : 2'b10;
    unique case (selSize)
      2'b00:   badReq = 1'b0;
      2'b01:   badReq = selAddr[0];
      2'b10:   badReq = (selAddr[1:0] != 2'b00);
      default: badReq = 1'b1;
    endcase
    // Leaving RELEASE with MFC still high can only mean the release phase timed out.
    finishErr = errFlag | bus.ramMFC;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state           <= IDLE;
      toCount         <= '0;
      errFlag         <= 1'b0;
      ownerData       <= 1'b0;
      lastGrant       <= 1'b0;
      bus.fetchDone   <= 1'b0;
      bus.fetchErr    <= 1'b0;
      bus.dataDone    <= 1'b0;
      bus.dataErr     <= 1'b0;
      bus.rdData      <= '0;
      bus.busy        <= 1'b0;
      bus.ramMFA      <= 1'b0;
      bus.ramRW       <= 1'b0;
      bus.ramDataSize <= 2'b00;
      bus.ramAddress  <= '0;
      bus.ramDataOut  <= '0;
    end else begin
      bus.fetchDone <= 1'b0;
      bus.fetchErr  <= 1'b0;
      bus.dataDone  <= 1'b0;
      bus.dataErr   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grantAny) begin
            bus.ramAddress  <= selAddr;
            bus.ramRW       <= selRW;
            bus.ramDataSize <= selSize;
            bus.ramDataOut  <= grantData ? bus.dataWrData : '0;
            ownerData       <= grantData;
            lastGrant       <= grantData;
            bus.busy        <= 1'b1;
            if (badReq) begin
              errFlag      <= 1'b1;
              bus.fetchErr <= ~grantData;
              bus.dataErr  <= grantData;
              state        <= DONE;
            end else begin
              errFlag    <= 1'b0;
              bus.ramMFA <= 1'b1;
              toCount    <= TO_ONE;
              state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (bus.ramMFC) begin
            if (bus.ramRW) bus.rdData <= bus.ramDataIn;
            bus.ramMFA <= 1'b0;
            toCount    <= TO_ONE;
            state      <= RELEASE;
          end else if (toCount == TO_LAST) begin
            errFlag    <= 1'b1;
            bus.ramMFA <= 1'b0;
            toCount    <= TO_ONE;
            state      <= RELEASE;
          end else begin
            toCount <= toCount + TO_ONE;
          end
        end
        RELEASE: begin
          if (!bus.ramMFC || toCount == TO_LAST) begin
            errFlag       <= finishErr;
            bus.fetchDone <= ~ownerData & ~finishErr;
            bus.fetchErr  <= ~ownerData &  finishErr;
            bus.dataDone  <=  ownerData & ~finishErr;
            bus.dataErr   <=  ownerData &  finishErr;
            state         <= DONE;
          end else begin
            toCount <= toCount + TO_ONE;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Scoreboard bench for ram_access_arbiter: directed requests push expected completions,
// a monitor pops and checks them on every Done/Err pulse; a simple RAM model answers MFA.
module tb_ram_access_arbiter;

  logic Clk = 1'b0;
  logic reset;
  always #5 Clk = ~Clk;

  ram_access_arbiter_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  ram_access_arbiter #(.ADDR_W(9), .DATA_W(32), .TIMEOUT(15), .TO_W(4)) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  // kind: 0 fetchDone, 1 fetchErr, 2 dataDone, 3 dataErr
  typedef struct {
    int          kind;
    bit          busChk;
    logic [8:0]  addr;
    logic        rw;
    logic [1:0]  size;
    bit          wrChk;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          mfa;
    int          busyc;
  } exp_t;

  exp_t sb[$];
  int testCount = 0;
  int failCount = 0;

  logic [31:0] memData   = '0;
  int          respDelay = 1;
  bit          respEnable = 1'b1;
  bit          holdMfc   = 1'b0;
  logic [31:0] rdModel   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // RAM model: raises MFC respDelay cycles into MFA, drops it once MFA falls.
  initial begin
    int cnt;
    cnt = 0;
    bus.ramMFC    = 1'b0;
    bus.ramDataIn = '0;
    forever begin
      @(negedge Clk);
      if (bus.ramMFA) begin
        cnt++;
        if (respEnable && cnt >= respDelay) begin
          bus.ramMFC    = 1'b1;
          bus.ramDataIn = memData;
        end
      end else begin
        cnt = 0;
        if (!holdMfc) bus.ramMFC = 1'b0;
      end
    end
  end

  // Monitor: counts MFA/busy cycles per transaction and checks each completion.
  initial begin
    int mfaCnt, busyCnt, nP, actKind;
    exp_t e;
    mfaCnt = 0;
    busyCnt = 0;
    forever begin
      @(negedge Clk);
      if (reset) begin
        mfaCnt = 0;
        busyCnt = 0;
      end else begin
        if (bus.ramMFA) mfaCnt++;
        if (bus.busy) busyCnt++;
        nP = int'(bus.fetchDone) + int'(bus.fetchErr) + int'(bus.dataDone) + int'(bus.dataErr);
        if (nP != 0) begin
          check("one_pulse", 32'(nP), 32'd1);
          actKind = bus.fetchDone ? 0 : bus.fetchErr ? 1 : bus.dataDone ? 2 : 3;
          if (sb.size() == 0) begin
            testCount++;
            failCount++;
            $display("FAIL unexpected_pulse: got kind %0d expected none", actKind);
          end else begin
            e = sb.pop_front();
            check("pulse_kind", 32'(actKind), 32'(e.kind));
            if (e.busChk) begin
              check("ramAddress", 32'(bus.ramAddress), 32'(e.addr));
              check("ramRW", 32'(bus.ramRW), 32'(e.rw));
              check("ramDataSize", 32'(bus.ramDataSize), 32'(e.size));
            end
            if (e.wrChk) check("ramDataOut", bus.ramDataOut, e.wdata);
            check("rdData", bus.rdData, e.rd);
            check("mfa_cycles", 32'(mfaCnt), 32'(e.mfa));
            check("busy_cycles", 32'(busyCnt), 32'(e.busyc));
          end
          mfaCnt = 0;
          busyCnt = 0;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic waitDone(input int bound);
    int n;
    n = 0;
    while ((bus.fetchReq || bus.dataReq) && n < bound) begin
      @(negedge Clk);
      n++;
      if (bus.fetchDone || bus.fetchErr) bus.fetchReq = 1'b0;
      if (bus.dataDone || bus.dataErr) bus.dataReq = 1'b0;
    end
    if (bus.fetchReq || bus.dataReq) begin
      testCount++;
      failCount++;
      $display("FAIL wait_done: got no completion in %0d cycles expected one", bound);
      bus.fetchReq = 1'b0;
      bus.dataReq  = 1'b0;
    end
  endtask

  function automatic exp_t mkExp(input int kind, input bit busChk, input logic [8:0] addr,
                                 input logic rw, input logic [1:0] size, input logic [31:0] wdata,
                                 input int mfa, input int busyc);
    exp_t e;
    e.kind = kind; e.busChk = busChk; e.addr = addr; e.rw = rw; e.size = size;
    e.wrChk = busChk && !rw; e.wdata = wdata; e.rd = rdModel; e.mfa = mfa; e.busyc = busyc;
    return e;
  endfunction

  // delay 0 means the RAM never answers.
  task automatic runOne(input bit isData, input logic rw, input logic [1:0] size,
                        input logic [8:0] addr, input logic [31:0] wdata, input int delay,
                        input logic [31:0] mem, input int kind, input int mfa, input int busyc);
    memData    = mem;
    respDelay  = delay;
    respEnable = (delay != 0);
    if ((kind == 0 || kind == 2) && rw) rdModel = mem;
    sb.push_back(mkExp(kind, mfa != 0, addr, rw, isData ? size : 2'b10, wdata, mfa, busyc));
    if (isData) begin
      bus.dataRW      = rw;
      bus.dataSize    = size;
      bus.dataAddress = addr;
      bus.dataWrData  = wdata;
      bus.dataReq     = 1'b1;
    end else begin
      bus.fetchAddress = addr;
      bus.fetchReq     = 1'b1;
    end
    waitDone(60);
    idle(2);
  endtask

  initial begin
    bit seen;
    reset            = 1'b1;
    bus.fetchReq     = 1'b0;
    bus.fetchAddress = '0;
    bus.dataReq      = 1'b0;
    bus.dataRW       = 1'b0;
    bus.dataSize     = 2'b00;
    bus.dataAddress  = '0;
    bus.dataWrData   = '0;
    idle(3);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_ramMFA", 32'(bus.ramMFA), 32'd0);
    check("rst_pulses", 32'({bus.fetchDone, bus.fetchErr, bus.dataDone, bus.dataErr}), 32'd0);
    check("rst_rdData", bus.rdData, 32'd0);
    check("rst_ramAddress", 32'(bus.ramAddress), 32'd0);
    check("rst_ramRW_size", 32'({bus.ramRW, bus.ramDataSize}), 32'd0);
    check("rst_ramDataOut", bus.ramDataOut, 32'd0);
    reset = 1'b0;
    idle(1);

    // Tie after reset: data A first, then a re-raised data B ties with fetch and fetch wins.
    memData = 32'h1234_5678; respDelay = 1; respEnable = 1'b1;
    rdModel = 32'h1234_5678;
    sb.push_back(mkExp(2, 1'b1, 9'h012, 1'b1, 2'b01, 32'h0, 1, 3));
    sb.push_back(mkExp(0, 1'b1, 9'h020, 1'b1, 2'b10, 32'h0, 1, 3));
    sb.push_back(mkExp(2, 1'b1, 9'h030, 1'b0, 2'b10, 32'hCAFE_F00D, 1, 3));
    bus.dataRW = 1'b1; bus.dataSize = 2'b01; bus.dataAddress = 9'h012;
    bus.fetchAddress = 9'h020;
    bus.dataReq = 1'b1; bus.fetchReq = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge Clk);
      if (bus.dataDone) seen = 1'b1;
    end
    if (!seen) begin
      testCount++;
      failCount++;
      $display("FAIL tie_first_data: got no dataDone expected one within 20 cycles");
    end
    bus.dataRW = 1'b0; bus.dataSize = 2'b10; bus.dataAddress = 9'h030;
    bus.dataWrData = 32'hCAFE_F00D;
    waitDone(60);
    idle(2);

    //      isData rw    size   addr    wdata          dly mem            kind mfa busy
    runOne(1'b0, 1'b1, 2'b10, 9'h004, 32'h0,         2,  32'h0022_1820, 0,   2,  4);
    runOne(1'b1, 1'b1, 2'b10, 9'h010, 32'h0,         1,  32'hDEAD_BEEF, 2,   1,  3);
    runOne(1'b1, 1'b1, 2'b10, 9'h003, 32'h0,         1,  32'h1111_1111, 3,   0,  1);
    runOne(1'b1, 1'b1, 2'b11, 9'h000, 32'h0,         1,  32'h2222_2222, 3,   0,  1);
    runOne(1'b1, 1'b1, 2'b01, 9'h005, 32'h0,         1,  32'h3333_3333, 3,   0,  1);
    runOne(1'b0, 1'b1, 2'b10, 9'h006, 32'h0,         1,  32'h4444_4444, 1,   0,  1);
    runOne(1'b1, 1'b0, 2'b00, 9'h003, 32'h8200_0000, 2,  32'h5555_5555, 2,   2,  4);
    runOne(1'b1, 1'b0, 2'b01, 9'h00A, 32'h0000_BEEF, 3,  32'h6666_6666, 2,   3,  5);
    runOne(1'b1, 1'b1, 2'b10, 9'h040, 32'h0,         0,  32'h7777_7777, 3,  15, 17);
    check("idle_after_timeout", 32'(bus.busy), 32'd0);
    runOne(1'b1, 1'b1, 2'b00, 9'h041, 32'h0,        15,  32'h0000_00C3, 2,  15, 17);
    runOne(1'b1, 1'b1, 2'b01, 9'h102, 32'h0,         1,  32'h0000_5A5A, 2,   1,  3);

    // MFC stuck high after MFA falls: release phase times out.
    memData = 32'h9999_9999; respDelay = 1; respEnable = 1'b1; holdMfc = 1'b1;
    sb.push_back(mkExp(3, 1'b1, 9'h007, 1'b0, 2'b00, 32'h0000_00AB, 1, 17));
    bus.dataRW = 1'b0; bus.dataSize = 2'b00; bus.dataAddress = 9'h007;
    bus.dataWrData = 32'h0000_00AB; bus.dataReq = 1'b1;
    waitDone(60);
    holdMfc = 1'b0;
    idle(2);

    // Reset in the middle of ISSUE discards the transaction.
    respEnable = 1'b0;
    bus.dataRW = 1'b1; bus.dataSize = 2'b10; bus.dataAddress = 9'h040; bus.dataReq = 1'b1;
    idle(3);
    check("mid_mfa_before_reset", 32'(bus.ramMFA), 32'd1);
    reset = 1'b1;
    bus.dataReq = 1'b0;
    idle(1);
    check("mid_rst_ramMFA", 32'(bus.ramMFA), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_rdData", bus.rdData, 32'd0);
    check("mid_rst_pulses", 32'({bus.fetchDone, bus.fetchErr, bus.dataDone, bus.dataErr}), 32'd0);
    idle(1);
    reset = 1'b0;
    rdModel = 32'h0;
    idle(1);
    runOne(1'b0, 1'b1, 2'b10, 9'h100, 32'h0, 1, 32'h0BAD_F00D, 0, 1, 3);

    idle(3);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
